lfm_chirp_ctrl: RTL and testbench
=================================

Name: lfm_chirp_ctrl

Overview:
- Linear-FM chirp sequencer that drives the NCO's phase_increment input.
- On start, sweeps the phase increment linearly from a programmed start value by a signed step each clock, for a programmed number of samples.
- Then idles for the remainder of the pulse repetition interval (PRI).
- Emits a gate/SOF/EOF aligned to the NCO sine/cosine outputs, for the downstream matched filter / pulse-compression capture.

Parameters:
- PHASE_WIDTH, 32, phase-increment width; must equal the NCO's PHASE_WIDTH.
- CNT_WIDTH, 16, width of the sample counters (pulse length, PRI length).
- NCO_LATENCY, 2, clocks from phase_increment change to the corresponding NCO output sample (accumulator register + ROM read).

Ports:
- clk  in  1  system clock
- rst  in  1  reset
- start  in  1  single-cycle request to emit one chirp; honoured only in IDLE
- cfg_start_inc  in  PHASE_WIDTH  phase increment of the first chirp sample (unsigned)
- cfg_step  in  PHASE_WIDTH  per-sample increment delta, two's complement (negative = down-chirp)
- cfg_pulse_len  in  CNT_WIDTH  chirp length in samples
- cfg_pri_len  in  CNT_WIDTH  total PRI length in samples, including the chirp
- phase_increment  out  PHASE_WIDTH  to NCO phase_increment
- busy  out  1  high in any state other than IDLE
- pulse_gate  out  1  high while NCO output carries chirp samples (delayed NCO_LATENCY)
- pulse_sof  out  1  one-cycle strobe on the first gated sample
- pulse_eof  out  1  one-cycle strobe on the last gated sample
- cfg_err  out  1  one-cycle strobe when start is rejected for bad config

Behaviour:
- Reset: rst is asynchronous, active-high; clock is clk. All outputs reset to 0; state = IDLE; delay line cleared.
- States: IDLE, SWEEP, LISTEN.
- IDLE:
  - phase_increment = 0 (NCO phase freezes).
  - On start: if cfg_pulse_len == 0 or cfg_pri_len < cfg_pulse_len, pulse cfg_err for 1 cycle and stay in IDLE.
  - Otherwise latch all cfg_* into shadow registers and go to SWEEP. cfg_* changes after that are ignored until the next IDLE.
- SWEEP:
  - Sample k (k = 0..pulse_len-1) occupies the k-th SWEEP cycle.
  - phase_increment = start_inc + k*step, computed incrementally (register += step), wrapping modulo 2^PHASE_WIDTH with no saturation.
  - Raw gate = 1; raw SOF at k = 0; raw EOF at k = pulse_len-1. pulse_len = 1 asserts SOF and EOF together.
  - After k = pulse_len-1: if pri_len == pulse_len, go to IDLE; else go to LISTEN.
- LISTEN:
  - phase_increment = 0 for pri_len - pulse_len cycles, then go to IDLE.
- Output alignment:
  - pulse_gate, pulse_sof and pulse_eof are the raw flags delayed by exactly NCO_LATENCY registers.
  - The phase_increment change is registered (no extra delay). The gate therefore lines up with the NCO output of sample k.
- busy rises the cycle after an accepted start and falls on return to IDLE.
- start is ignored while busy; no queuing.
- The earliest re-start is the cycle busy is low. Back-to-back PRIs lose 1 IDLE cycle, except under LFM_AUTO_REPEAT_EN.
- rst mid-pulse: immediate return to IDLE. phase_increment = 0; gate/SOF/EOF pipeline cleared, so no EOF is produced for the aborted pulse.

Optional Feature:
- Macro: LFM_AUTO_REPEAT_EN.
- Defined:
  - Extra input stop (1 bit).
  - After LISTEN (or SWEEP when pri_len == pulse_len), the block re-enters SWEEP directly with reloaded start_inc. This gives zero-gap continuous PRIs using the same latched config.
  - stop (any cycle while busy) is registered and takes effect at the next PRI boundary, returning to IDLE.
  - A stop and a PRI boundary in the same cycle end the sequence.
- Undefined: port absent; exactly one PRI per start.

Decomposition:
- Shared package radar_pkg:
  - PHASE_WIDTH and CNT_WIDTH defaults.
  - Chirp state encoding (IDLE = 0, SWEEP = 1, LISTEN = 2).
  - NCO_LATENCY constant shared with nco.
- One sub-module, lfm_align_dly: a 3-bit-wide, NCO_LATENCY-deep shift register with async reset, carrying gate/SOF/EOF.

Test Plan:
- Basic up-chirp, cfg_start_inc=0x01000000, cfg_step=0x00010000, cfg_pulse_len=4, cfg_pri_len=10, single start:
  - phase_increment = 0x01000000, 0x01010000, 0x01020000, 0x01030000, then 0 for 6 cycles.
  - pulse_gate high 4 cycles starting 2 cycles after first nonzero increment; SOF/EOF on first/last; busy high 10 cycles.
- Down-chirp wrap, start_inc=0x00000001, step=0xFFFFFFFE, len=3:
  - Increments 0x00000001, 0xFFFFFFFF, 0xFFFFFFFD.
- Bad config:
  - pulse_len=0 -> cfg_err for 1 cycle, busy stays 0.
  - pri_len=3, pulse_len=5 -> cfg_err for 1 cycle, busy stays 0.
- pulse_len=1, pri_len=1:
  - One increment cycle; SOF and EOF coincide 2 cycles later; busy high 1 cycle.
- Abort and re-start:
  - start held every cycle during busy -> no second pulse until IDLE.
  - rst asserted at k=2 of len=8 -> all outputs 0 asynchronously; no EOF seen.
- With LFM_AUTO_REPEAT_EN, len=4, pri=6:
  - 3 consecutive PRIs with no IDLE gap.
  - stop during PRI 3 -> returns to IDLE after PRI 3 LISTEN completes.

Source files
------------

// File: rtl/radar_pkg.sv
// Shared radar front-end constants and chirp sequencer state encoding.
// Used by the chirp controller, its alignment delay and the NCO.
package radar_pkg;
  localparam int RADAR_PHASE_WIDTH = 32;
  localparam int RADAR_CNT_WIDTH   = 16;
  localparam int RADAR_NCO_LATENCY = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SWEEP  = 2'd1,
    LISTEN = 2'd2
  } chirp_state_t;
endpackage

// File: rtl/lfm_align_dly.sv
// Fixed-depth shift register carrying {gate, sof, eof} alongside the NCO pipeline.
// Latency DEPTH clocks; no backpressure, advances every clock.
module lfm_align_dly
  import radar_pkg::*;
#(
  parameter int DEPTH = RADAR_NCO_LATENCY
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] d,
  output logic [2:0] q
);
  logic [2:0] sr [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) sr[i] <= '0;
    end else begin
      sr[0] <= d;
      for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
    end
  end

  assign q = sr[DEPTH-1];
endmodule

// File: rtl/lfm_chirp_ctrl.sv
// Linear-FM chirp sequencer driving NCO phase_increment; gate/SOF/EOF delayed NCO_LATENCY to match NCO output.
// No backpressure; optional LFM_AUTO_REPEAT_EN adds a stop input and back-to-back PRIs.
module lfm_chirp_ctrl
  import radar_pkg::*;
#(
  parameter int PHASE_WIDTH = RADAR_PHASE_WIDTH,
  parameter int CNT_WIDTH   = RADAR_CNT_WIDTH,
  parameter int NCO_LATENCY = RADAR_NCO_LATENCY
) (
  input  logic                   clk,
  input  logic                   rst,
`ifdef LFM_AUTO_REPEAT_EN
  input  logic                   stop,
`endif
  input  logic                   start,
  input  logic [PHASE_WIDTH-1:0] cfg_start_inc,
  input  logic [PHASE_WIDTH-1:0] cfg_step,
  input  logic [CNT_WIDTH-1:0]   cfg_pulse_len,
  input  logic [CNT_WIDTH-1:0]   cfg_pri_len,
  output logic [PHASE_WIDTH-1:0] phase_increment,
  output logic                   busy,
  output logic                   pulse_gate,
  output logic                   pulse_sof,
  output logic                   pulse_eof,
  output logic                   cfg_err
);
  localparam logic [CNT_WIDTH-1:0] ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  chirp_state_t           state;
  logic [PHASE_WIDTH-1:0] inc_q, start_inc_sh, step_sh;
  logic [CNT_WIDTH-1:0]   pulse_len_sh, pri_len_sh, cnt;
  logic                   raw_gate, raw_sof, raw_eof;
  logic [2:0]             dly_q;
`ifdef LFM_AUTO_REPEAT_EN
  logic                   stop_req;
`endif

  logic cfg_bad, sweep_last, listen_last, pri_end;
  assign cfg_bad     = (cfg_pulse_len == '0) || (cfg_pri_len < cfg_pulse_len);
  assign sweep_last  = (cnt == pulse_len_sh - ONE);
  assign listen_last = (cnt == pri_len_sh - pulse_len_sh - ONE);
  // PRI boundary: last sweep sample with no listen window, or last listen cycle.
  assign pri_end = ((state == SWEEP) && sweep_last && (pri_len_sh == pulse_len_sh)) ||
                   ((state == LISTEN) && listen_last);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      busy         <= 1'b0;
      cfg_err      <= 1'b0;
      inc_q        <= '0;
      cnt          <= '0;
      start_inc_sh <= '0;
      step_sh      <= '0;
      pulse_len_sh <= '0;
      pri_len_sh   <= '0;
      raw_gate     <= 1'b0;
      raw_sof      <= 1'b0;
      raw_eof      <= 1'b0;
`ifdef LFM_AUTO_REPEAT_EN
      stop_req     <= 1'b0;
`endif
    end else begin
      cfg_err <= 1'b0;
      case (state)
        IDLE: begin
`ifdef LFM_AUTO_REPEAT_EN
          stop_req <= 1'b0;
`endif
          if (start) begin
            if (cfg_bad) begin
              cfg_err <= 1'b1;
            end else begin
              start_inc_sh <= cfg_start_inc;
              step_sh      <= cfg_step;
              pulse_len_sh <= cfg_pulse_len;
              pri_len_sh   <= cfg_pri_len;
              state        <= SWEEP;
              busy         <= 1'b1;
              inc_q        <= cfg_start_inc;
              cnt          <= '0;
              raw_gate     <= 1'b1;
              raw_sof      <= 1'b1;
              raw_eof      <= (cfg_pulse_len == ONE);
            end
          end
        end
        SWEEP, LISTEN: begin
`ifdef LFM_AUTO_REPEAT_EN
          stop_req <= stop_req | stop;
`endif
          if (pri_end) begin
`ifdef LFM_AUTO_REPEAT_EN
            if (!(stop || stop_req)) begin
              state    <= SWEEP;
              inc_q    <= start_inc_sh;
              cnt      <= '0;
              raw_gate <= 1'b1;
              raw_sof  <= 1'b1;
              raw_eof  <= (pulse_len_sh == ONE);
            end else begin
              stop_req <= 1'b0;
              state    <= IDLE;
              busy     <= 1'b0;
              inc_q    <= '0;
              cnt      <= '0;
              raw_gate <= 1'b0;
              raw_sof  <= 1'b0;
              raw_eof  <= 1'b0;
            end
`else
            state    <= IDLE;
            busy     <= 1'b0;
            inc_q    <= '0;
            cnt      <= '0;
            raw_gate <= 1'b0;
            raw_sof  <= 1'b0;
            raw_eof  <= 1'b0;
`endif
          end else if (state == SWEEP) begin
            if (sweep_last) begin
              state    <= LISTEN;
              inc_q    <= '0;
              cnt      <= '0;
              raw_gate <= 1'b0;
              raw_sof  <= 1'b0;
              raw_eof  <= 1'b0;
            end else begin
              inc_q   <= inc_q + step_sh;
              cnt     <= cnt + ONE;
              raw_sof <= 1'b0;
              raw_eof <= (cnt + ONE == pulse_len_sh - ONE);
            end
          end else begin
            cnt <= cnt + ONE;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  lfm_align_dly #(.DEPTH(NCO_LATENCY)) u_align_dly (
    .clk (clk),
    .rst (rst),
    .d   ({raw_gate, raw_sof, raw_eof}),
    .q   (dly_q)
  );

  assign phase_increment = inc_q;
  assign pulse_gate      = dly_q[2];
  assign pulse_sof       = dly_q[1];
  assign pulse_eof       = dly_q[0];
endmodule

// File: tb/tb_lfm_chirp_ctrl.sv
// Bench for lfm_chirp_ctrl: table vectors, hand corner sequences and random stimulus vs a PRI-position model.
module tb_lfm_chirp_ctrl;
  logic        clk, rst, start;
  logic [31:0] cfg_start_inc, cfg_step, phase_increment;
  logic [15:0] cfg_pulse_len, cfg_pri_len;
  logic        busy, pulse_gate, pulse_sof, pulse_eof, cfg_err;
`ifdef LFM_AUTO_REPEAT_EN
  logic        stop;
`endif

  int checks = 0;
  int errors = 0;

  lfm_chirp_ctrl dut (
    .clk             (clk),
    .rst             (rst),
`ifdef LFM_AUTO_REPEAT_EN
    .stop            (stop),
`endif
    .start           (start),
    .cfg_start_inc   (cfg_start_inc),
    .cfg_step        (cfg_step),
    .cfg_pulse_len   (cfg_pulse_len),
    .cfg_pri_len     (cfg_pri_len),
    .phase_increment (phase_increment),
    .busy            (busy),
    .pulse_gate      (pulse_gate),
    .pulse_sof       (pulse_sof),
    .pulse_eof       (pulse_eof),
    .cfg_err         (cfg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Reference model: position within the current PRI, -1 when idle.
  int          m_pos = -1;
  int          m_pl = 0, m_pr = 0;
  logic [31:0] m_si = '0, m_st = '0, m_inc = '0;
  bit          m_err = 0, m_stop_req = 0;
  bit [2:0]    m_raw = '0, m_d1 = '0, m_d2 = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pos = -1; m_inc = '0; m_err = 0; m_stop_req = 0;
      m_raw = '0; m_d1 = '0; m_d2 = '0;
    end else begin
      bit was_busy;
      bit stop_now;
      was_busy = (m_pos >= 0);
      stop_now = 0;
`ifdef LFM_AUTO_REPEAT_EN
      stop_now = stop;
`endif
      m_err = 0;
      if (m_pos < 0) begin
        if (start) begin
          if (cfg_pulse_len == 0 || cfg_pri_len < cfg_pulse_len) m_err = 1;
          else begin
            m_si = cfg_start_inc; m_st = cfg_step;
            m_pl = int'(cfg_pulse_len); m_pr = int'(cfg_pri_len);
            m_pos = 0;
          end
        end
      end else begin
        m_pos++;
        if (m_pos == m_pr) begin
`ifdef LFM_AUTO_REPEAT_EN
          m_pos = (stop_now || m_stop_req) ? -1 : 0;
`else
          m_pos = -1;
`endif
        end
      end
      if (m_pos < 0) m_stop_req = 0;
      else if (was_busy && stop_now) m_stop_req = 1;
      m_d2 = m_d1;
      m_d1 = m_raw;
      if (m_pos >= 0 && m_pos < m_pl) begin
        m_inc = m_si + m_st * 32'(m_pos);
        m_raw = {1'b1, m_pos == 0, m_pos == m_pl - 1};
      end else begin
        m_inc = '0;
        m_raw = '0;
      end
    end
  end

  always @(negedge clk) begin
    check("cyc_phase", phase_increment, m_inc);
    check("cyc_busy", 32'(busy), 32'(m_pos >= 0));
    check("cyc_gate", 32'(pulse_gate), 32'(m_d2[2]));
    check("cyc_sof", 32'(pulse_sof), 32'(m_d2[1]));
    check("cyc_eof", 32'(pulse_eof), 32'(m_d2[0]));
    check("cyc_err", 32'(cfg_err), 32'(m_err));
  end

  logic [31:0] lg_inc [64];
  bit          lg_busy [64], lg_gate [64], lg_sof [64], lg_eof [64], lg_err [64];

  task automatic run_pulse(input logic [31:0] si, input logic [31:0] st, input int pl, input int pr,
                           input bit hold, input int stop_at, input int ncyc);
    @(negedge clk);
    cfg_start_inc = si; cfg_step = st;
    cfg_pulse_len = 16'(pl); cfg_pri_len = 16'(pr);
    start = 1'b1;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      if (!hold) start = 1'b0;
`ifdef LFM_AUTO_REPEAT_EN
      stop = (stop_at < 0) ? 1'b1 : (i == stop_at);
`endif
      lg_inc[i] = phase_increment; lg_busy[i] = busy; lg_gate[i] = pulse_gate;
      lg_sof[i] = pulse_sof; lg_eof[i] = pulse_eof; lg_err[i] = cfg_err;
    end
    start = 1'b0;
`ifdef LFM_AUTO_REPEAT_EN
    stop = 1'b0;
`endif
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200 && busy; i++) @(negedge clk);
    check("idle_timeout", 32'(busy), 32'd0);
    @(negedge clk);
  endtask

  typedef struct {
    logic [31:0] si, st;
    int          pl, pr;
    bit          err;
    logic [31:0] inc0, inc1, incl;
    int          gates, busys;
  } vec_t;
  vec_t tv [6];

  initial begin
    int n_err, n_gate, n_busy, sof_idx, eof_idx, n_sof, n_eof;
    tv[0] = '{32'h01000000, 32'h00010000, 4, 10, 0, 32'h01000000, 32'h01010000, 32'h01030000, 4, 10};
    tv[1] = '{32'h00000001, 32'hFFFFFFFE, 3, 3, 0, 32'h00000001, 32'hFFFFFFFF, 32'hFFFFFFFD, 3, 3};
    tv[2] = '{32'h01000000, 32'h00010000, 0, 5, 1, 32'h0, 32'h0, 32'h0, 0, 0};
    tv[3] = '{32'h01000000, 32'h00010000, 5, 3, 1, 32'h0, 32'h0, 32'h0, 0, 0};
    tv[4] = '{32'h12345678, 32'h00000005, 1, 1, 0, 32'h12345678, 32'h0, 32'h12345678, 1, 1};
    tv[5] = '{32'h80000000, 32'hFFFF0000, 5, 7, 0, 32'h80000000, 32'h7FFF0000, 32'h7FFC0000, 5, 7};

    start = 0; cfg_start_inc = '0; cfg_step = '0; cfg_pulse_len = '0; cfg_pri_len = '0;
`ifdef LFM_AUTO_REPEAT_EN
    stop = 0;
`endif
    rst = 0;
    #1 rst = 1;
    repeat (3) @(negedge clk);
    check("reset_phase", phase_increment, 32'd0);
    check("reset_flags", {26'd0, busy, pulse_gate, pulse_sof, pulse_eof, cfg_err, 1'b0}, 32'd0);
    rst = 0;
    @(negedge clk);

    for (int v = 0; v < 6; v++) begin
      run_pulse(tv[v].si, tv[v].st, tv[v].pl, tv[v].pr, 0, -1, 30);
      n_err = 0; n_gate = 0; n_busy = 0; sof_idx = -1; eof_idx = -1;
      for (int i = 0; i < 30; i++) begin
        n_err += lg_err[i]; n_gate += lg_gate[i]; n_busy += lg_busy[i];
        if (lg_sof[i] && sof_idx < 0) sof_idx = i;
        if (lg_eof[i] && eof_idx < 0) eof_idx = i;
      end
      check($sformatf("tv%0d_err", v), 32'(n_err), 32'(tv[v].err));
      check($sformatf("tv%0d_inc0", v), lg_inc[0], tv[v].inc0);
      check($sformatf("tv%0d_inc1", v), lg_inc[1], tv[v].inc1);
      check($sformatf("tv%0d_incl", v), lg_inc[tv[v].pl > 0 ? tv[v].pl - 1 : 0], tv[v].incl);
      check($sformatf("tv%0d_gates", v), 32'(n_gate), 32'(tv[v].gates));
      check($sformatf("tv%0d_busy", v), 32'(n_busy), 32'(tv[v].busys));
      if (!tv[v].err) begin
        check($sformatf("tv%0d_sof_idx", v), 32'(sof_idx), 32'd2);
        check($sformatf("tv%0d_eof_idx", v), 32'(eof_idx), 32'(tv[v].pl + 1));
      end
      wait_idle();
    end

    // start held high: restart only at the single IDLE cycle between PRIs
    run_pulse(32'h00100000, 32'h00000100, 4, 6, 1, -1, 16);
    check("hold_busy5", 32'(lg_busy[5]), 32'd1);
    check("hold_busy6", 32'(lg_busy[6]), 32'd0);
    check("hold_busy7", 32'(lg_busy[7]), 32'd1);
    n_sof = 0;
    for (int i = 0; i < 8; i++) n_sof += lg_sof[i];
    check("hold_one_sof", 32'(n_sof), 32'd1);
    check("hold_restart_inc", lg_inc[7], 32'h00100000);
    wait_idle();

    // asynchronous reset at sample k=2 of an 8-sample chirp
    @(negedge clk);
    cfg_start_inc = 32'h02000000; cfg_step = 32'h00001000;
    cfg_pulse_len = 16'd8; cfg_pri_len = 16'd12;
    start = 1;
    @(negedge clk); start = 0;
    @(negedge clk);
    @(negedge clk);
    check("abort_pre_inc", phase_increment, 32'h02002000);
    #2 rst = 1;
    #1;
    check("abort_phase", phase_increment, 32'd0);
    check("abort_flags", {27'd0, busy, pulse_gate, pulse_sof, pulse_eof, cfg_err}, 32'd0);
    @(negedge clk); rst = 0;
    n_eof = 0; n_gate = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      n_eof += pulse_eof; n_gate += pulse_gate;
    end
    check("abort_no_eof", 32'(n_eof), 32'd0);
    check("abort_no_gate", 32'(n_gate), 32'd0);

`ifdef LFM_AUTO_REPEAT_EN
    // continuous PRIs, stop during the third
    run_pulse(32'h00400000, 32'h00000010, 4, 6, 0, 13, 24);
    n_busy = 0; n_sof = 0;
    for (int i = 0; i < 18; i++) begin
      n_busy += lg_busy[i]; n_sof += lg_sof[i];
    end
    check("auto_busy_cont", 32'(n_busy), 32'd18);
    check("auto_sof3", 32'(n_sof), 32'd3);
    check("auto_sof_pri3", 32'(lg_sof[14]), 32'd1);
    check("auto_reload", lg_inc[6], 32'h00400000);
    check("auto_idle", 32'(lg_busy[18]), 32'd0);
    wait_idle();
`endif

    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 199) == 0);
      start = ($urandom_range(0, 2) == 0);
      cfg_start_inc = $urandom;
      cfg_step = $urandom;
      cfg_pulse_len = 16'($urandom_range(0, 6));
      cfg_pri_len = 16'($urandom_range(0, 10));
`ifdef LFM_AUTO_REPEAT_EN
      stop = ($urandom_range(0, 7) == 0);
`endif
    end
    @(negedge clk);
    rst = 0; start = 0;
`ifdef LFM_AUTO_REPEAT_EN
    stop = 1;
`endif
    wait_idle();
`ifdef LFM_AUTO_REPEAT_EN
    stop = 0;
`endif
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
